// File: rtl/risc_loader_pkg.sv
// Shared types and helpers for the framed instruction-memory loader.
// Holds the FSM state encoding, the default header byte and word-size math.
package risc_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CHECK = 3'd4,
    ST_RUN   = 3'd5
  } state_t;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  function automatic int bytes_per_word(input int instr_w);
    return instr_w / 8;
  endfunction

endpackage

// File: rtl/risc_byte_packer.sv
// Little-endian byte-to-word packer: the first byte of a word lands in the low lane.
// word is the completed word combinationally while the final byte is being shifted.
module risc_byte_packer
  import risc_loader_pkg::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift_en,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               word_done
);

  localparam int BPW = bytes_per_word(INSTR_W);
  localparam logic [2:0] LAST = 3'(BPW - 1);

  logic [2:0] cnt_q, cnt_d;

  assign word_done = shift_en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 3'd0;
    end else if (shift_en) begin
      cnt_d = word_done ? 3'd0 : cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 3'd0;
    else     cnt_q <= cnt_d;
  end

  generate
    if (BPW > 1) begin : g_shift
      // Holds the earlier bytes of the word; the newest byte always enters at the top.
      logic [INSTR_W-9:0] shreg_q, shreg_d;

      assign word = {byte_in, shreg_q};

      always_comb begin
        shreg_d = shreg_q;
        if (clr)           shreg_d = '0;
        else if (shift_en) shreg_d = word[INSTR_W-1:8];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) shreg_q <= '0;
        else     shreg_q <= shreg_d;
      end
    end else begin : g_pass
      assign word = byte_in;
    end
  endgenerate

endmodule

// File: rtl/risc_prog_loader.sv
// Framed, checksummed program loader: HDR, N, A, N words of data, C.
// Writes each completed word into instruction memory and releases the core on a good checksum.
module risc_prog_loader
  import risc_loader_pkg::*;
#(
  parameter int         INSTR_W = 16,
  parameter int         ADDR_W  = 7,
  parameter logic [7:0] HDR     = HDR_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  output logic               cpu_run,
  output logic               err,
  output logic [7:0]         words_loaded,
  output logic [7:0]         status
);

  state_t             state_q, state_d;
  logic [7:0]         n_q, n_d, sum_q, sum_d, wl_q, wl_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [INSTR_W-1:0] mem_wdata_q, mem_wdata_d, word;
  logic               mem_we_q, mem_we_d, cpu_run_q, cpu_run_d, err_q, err_d;
  logic               accept, frame_start, shift_en, word_done, last_word;
  logic [7:0]         sum_next;

  // Stalling input during the write cycle keeps at most one write in flight.
  assign byte_ready  = !mem_we_q;
  assign accept      = byte_valid && byte_ready;
  assign frame_start = accept && (byte_in == HDR) &&
                       (state_q == ST_IDLE || state_q == ST_RUN);
  assign shift_en    = accept && (state_q == ST_DATA);
  assign sum_next    = sum_q + byte_in;
  assign last_word   = ({1'b0, wl_q} + 9'd1) == {1'b0, n_q};

  risc_byte_packer #(.INSTR_W(INSTR_W)) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (frame_start),
    .shift_en  (shift_en),
    .byte_in   (byte_in),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RUN: if (frame_start) state_d = ST_COUNT;
      ST_COUNT:        if (accept) state_d = ST_ADDR;
      ST_ADDR:         if (accept) state_d = (n_q != 8'd0) ? ST_DATA : ST_CHECK;
      ST_DATA:         if (word_done && last_word) state_d = ST_CHECK;
      ST_CHECK:        if (accept) state_d = (sum_next == 8'd0) ? ST_RUN : ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    n_d         = n_q;
    sum_d       = sum_q;
    wl_d        = wl_q;
    addr_d      = addr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    cpu_run_d   = cpu_run_q;
    err_d       = err_q;
    if (frame_start) begin
      err_d     = 1'b0;
      wl_d      = 8'd0;
      cpu_run_d = 1'b0;
      sum_d     = 8'd0;
    end
    if (accept && state_q == ST_COUNT) n_d = byte_in;
    if (accept && state_q == ST_ADDR)  addr_d = byte_in[ADDR_W-1:0];
    if (shift_en) begin
      sum_d = sum_next;
      if (word_done) begin
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = word;
        addr_d      = addr_q + ADDR_W'(1);
        if (wl_q != 8'hFF) wl_d = wl_q + 8'd1;
      end
    end
    if (accept && state_q == ST_CHECK) begin
      if (sum_next == 8'd0) cpu_run_d = 1'b1;
      else                  err_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q         <= 8'd0;
      sum_q       <= 8'd0;
      wl_q        <= 8'd0;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      cpu_run_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      n_q         <= n_d;
      sum_q       <= sum_d;
      wl_q        <= wl_d;
      addr_q      <= addr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      cpu_run_q   <= cpu_run_d;
      err_q       <= err_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_run      = cpu_run_q;
  assign err          = err_q;
  assign words_loaded = wl_q;
  assign status       = {err_q, cpu_run_q, 3'b000, state_q};

endmodule
